// File: rtl/cache_fill_responder.sv
// Cache line fill responder: fetches a 4x16-bit line critical-word-first and
// streams it to the cache, or performs a single byte-enabled word write.
module cache_fill_responder (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_req_addr,
    input  logic        i_req_rw,
    input  logic [15:0] i_req_wdata,
    input  logic        i_req_wrl,
    input  logic        i_req_wru,
    output logic        o_fill,
    output logic [15:0] o_rdata,
    output logic        o_wr_ack,
    output logic        o_busy,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_we,
    output logic [15:0] o_mem_wdata,
    output logic [1:0]  o_mem_bsel,
    input  logic [15:0] i_mem_rdata,
    input  logic        i_mem_ack
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_FILL    = 3'd2,
        S_STREAM  = 3'd3,
        S_WRITE   = 3'd4,
        S_RELEASE = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [28:0] r_line;
    logic [28:0] w_line_nxt;
    logic [1:0]  r_idx;
    logic [1:0]  w_idx_nxt;
    logic [1:0]  r_cnt;
    logic [1:0]  w_cnt_nxt;
    logic [1:0]  r_scnt;
    logic [1:0]  w_scnt_nxt;
    logic [15:0] r_buf [0:3];
    logic        w_buf_we;
    logic [1:0]  w_word_k;
    logic [1:0]  w_slot_next;

    logic        r_fill,      w_fill_nxt;
    logic [15:0] r_rdata,     w_rdata_nxt;
    logic        r_wr_ack,    w_wr_ack_nxt;
    logic        r_busy,      w_busy_nxt;
    logic        r_mem_req,   w_mem_req_nxt;
    logic [31:0] r_mem_addr,  w_mem_addr_nxt;
    logic        r_mem_we,    w_mem_we_nxt;
    logic [15:0] r_mem_wdata, w_mem_wdata_nxt;
    logic [1:0]  r_mem_bsel,  w_mem_bsel_nxt;

    // Byte address bit 0 never reaches memory: accesses are word aligned.
    logic w_unused_addr0;
    assign w_unused_addr0 = i_req_addr[0];

    // Wrap-around word order within the line, critical word first.
    assign w_word_k    = r_idx + r_cnt + 2'd1;
    assign w_slot_next = r_scnt + 2'd1;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-output decode; outputs are registered below.
    always_comb begin
        w_state_nxt     = r_state;
        w_line_nxt      = r_line;
        w_idx_nxt       = r_idx;
        w_cnt_nxt       = r_cnt;
        w_scnt_nxt      = r_scnt;
        w_buf_we        = 1'b0;
        w_fill_nxt      = 1'b0;
        w_wr_ack_nxt    = 1'b0;
        w_rdata_nxt     = r_rdata;
        w_mem_req_nxt   = r_mem_req;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_we_nxt    = r_mem_we;
        w_mem_wdata_nxt = r_mem_wdata;
        w_mem_bsel_nxt  = r_mem_bsel;
        case (r_state)
            S_IDLE: begin
                if (i_req) begin
                    w_line_nxt    = i_req_addr[31:3];
                    w_idx_nxt     = i_req_addr[2:1];
                    w_cnt_nxt     = 2'd0;
                    w_mem_req_nxt = 1'b1;
                    if (i_req_rw) begin
                        w_state_nxt    = S_FETCH;
                        w_mem_addr_nxt = {i_req_addr[31:3], i_req_addr[2:1], 1'b0};
                        w_mem_we_nxt   = 1'b0;
                        w_mem_bsel_nxt = 2'b11;
                    end else begin
                        w_state_nxt     = S_WRITE;
                        w_mem_addr_nxt  = {i_req_addr[31:1], 1'b0};
                        w_mem_we_nxt    = 1'b1;
                        w_mem_wdata_nxt = i_req_wdata;
                        w_mem_bsel_nxt  = {i_req_wru, i_req_wrl};
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_FETCH: begin
                if (i_mem_ack) begin
                    w_buf_we = 1'b1;
                    if (r_cnt == 2'd3) begin
                        w_mem_req_nxt = 1'b0;
                        // A request withdrawn mid-burst is dropped once memory is quiet.
                        if (i_req) begin
                            w_state_nxt = S_FILL;
                            w_fill_nxt  = 1'b1;
                            w_rdata_nxt = r_buf[0];
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_cnt_nxt      = r_cnt + 2'd1;
                        w_mem_addr_nxt = {r_line, w_word_k, 1'b0};
                    end
                end else begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FILL: begin
                w_state_nxt = S_STREAM;
                w_scnt_nxt  = 2'd1;
                w_rdata_nxt = r_buf[1];
            end
            S_STREAM: begin
                if (r_scnt == 2'd3) begin
                    w_state_nxt = S_RELEASE;
                end else begin
                    w_scnt_nxt  = w_slot_next;
                    w_rdata_nxt = r_buf[w_slot_next];
                end
            end
            S_WRITE: begin
                if (i_mem_ack) begin
                    w_state_nxt    = S_RELEASE;
                    w_mem_req_nxt  = 1'b0;
                    w_mem_we_nxt   = 1'b0;
                    w_mem_bsel_nxt = 2'b11;
                    w_wr_ack_nxt   = 1'b1;
                end else begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_RELEASE: begin
                if (!i_req) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RELEASE;
                end
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_mem_req_nxt  = 1'b0;
                w_mem_we_nxt   = 1'b0;
                w_mem_bsel_nxt = 2'b11;
            end
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // Datapath, line buffer and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_line      <= 29'd0;
            r_idx       <= 2'd0;
            r_cnt       <= 2'd0;
            r_scnt      <= 2'd0;
            r_buf[0]    <= 16'd0;
            r_buf[1]    <= 16'd0;
            r_buf[2]    <= 16'd0;
            r_buf[3]    <= 16'd0;
            r_fill      <= 1'b0;
            r_rdata     <= 16'd0;
            r_wr_ack    <= 1'b0;
            r_busy      <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= 16'd0;
            r_mem_bsel  <= 2'b11;
        end else begin
            r_line      <= w_line_nxt;
            r_idx       <= w_idx_nxt;
            r_cnt       <= w_cnt_nxt;
            r_scnt      <= w_scnt_nxt;
            if (w_buf_we) begin
                r_buf[r_cnt] <= i_mem_rdata;
            end
            r_fill      <= w_fill_nxt;
            r_rdata     <= w_rdata_nxt;
            r_wr_ack    <= w_wr_ack_nxt;
            r_busy      <= w_busy_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_mem_bsel  <= w_mem_bsel_nxt;
        end
    end

    assign o_fill      = r_fill;
    assign o_rdata     = r_rdata;
    assign o_wr_ack    = r_wr_ack;
    assign o_busy      = r_busy;
    assign o_mem_req   = r_mem_req;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_we    = r_mem_we;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_bsel  = r_mem_bsel;

endmodule

// File: tb/tb_cache_fill_responder.sv
// Scoreboard bench for cache_fill_responder: a memory model acks 2 cycles after
// each address, and a monitor pops expected accesses, fill data and write acks.
module tb_cache_fill_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_req_addr;
    logic        i_req_rw;
    logic [15:0] i_req_wdata;
    logic        i_req_wrl;
    logic        i_req_wru;
    logic        o_fill;
    logic [15:0] o_rdata;
    logic        o_wr_ack;
    logic        o_busy;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        o_mem_we;
    logic [15:0] o_mem_wdata;
    logic [1:0]  o_mem_bsel;
    logic [15:0] i_mem_rdata;
    logic        i_mem_ack;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [1:0]  bsel;
        logic [15:0] wdata;
    } acc_t;

    acc_t        exp_mem [$];
    logic [15:0] exp_rd [$];
    int          exp_wack   = 0;
    int          n_acc      = 0;
    int          stray_req  = 0;
    int          stray_seen = 0;
    int          n_vec      = 0;
    int          n_err      = 0;

    cache_fill_responder dut (
        .clk         (clk),
        .reset       (reset),
        .i_req       (i_req),
        .i_req_addr  (i_req_addr),
        .i_req_rw    (i_req_rw),
        .i_req_wdata (i_req_wdata),
        .i_req_wrl   (i_req_wrl),
        .i_req_wru   (i_req_wru),
        .o_fill      (o_fill),
        .o_rdata     (o_rdata),
        .o_wr_ack    (o_wr_ack),
        .o_busy      (o_busy),
        .o_mem_req   (o_mem_req),
        .o_mem_addr  (o_mem_addr),
        .o_mem_we    (o_mem_we),
        .o_mem_wdata (o_mem_wdata),
        .o_mem_bsel  (o_mem_bsel),
        .i_mem_rdata (i_mem_rdata),
        .i_mem_ack   (i_mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_mem(input logic [31:0] a, input logic we, input logic [1:0] bs, input logic [15:0] wd);
        acc_t e;
        e.addr = a; e.we = we; e.bsel = bs; e.wdata = wd;
        exp_mem.push_back(e);
    endtask

    // Memory model: data word = 0x1111 * word-in-line index.
    initial begin
        int cnt;
        bit pend;
        logic [31:0] a;
        acc_t e;
        cnt = 0; pend = 1'b0; a = 32'd0;
        i_mem_ack = 1'b0;
        i_mem_rdata = 16'd0;
        forever begin
            @(posedge clk);
            #1;
            i_mem_ack = 1'b0;
            if (stray_req != stray_seen) begin
                stray_seen++;
                i_mem_ack = 1'b1;
                i_mem_rdata = 16'hDEAD;
            end else if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    i_mem_ack = 1'b1;
                    i_mem_rdata = 16'h1111 * {14'd0, a[2:1]};
                    pend = 1'b0;
                end
            end else if (o_mem_req && reset) begin
                pend = 1'b1;
                cnt = 2;
                a = o_mem_addr;
                n_acc++;
                chk("mem_access_expected", {31'd0, exp_mem.size() > 0}, 32'd1);
                if (exp_mem.size() > 0) begin
                    e = exp_mem.pop_front();
                    chk("mem_addr", o_mem_addr, e.addr);
                    chk("mem_we", {31'd0, o_mem_we}, {31'd0, e.we});
                    chk("mem_bsel", {30'd0, o_mem_bsel}, {30'd0, e.bsel});
                    if (e.we) chk("mem_wdata", {16'd0, o_mem_wdata}, {16'd0, e.wdata});
                end
            end
        end
    end

    // Monitor: fill/stream data and write acknowledge.
    initial begin
        int stream_left;
        logic prev_ack;
        stream_left = 0;
        prev_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                stream_left = 0;
                prev_ack = 1'b0;
            end else begin
                if (o_fill) begin
                    chk("fill_expected", {31'd0, exp_rd.size() > 0}, 32'd1);
                    if (exp_rd.size() > 0) chk("fill_rdata", {16'd0, o_rdata}, {16'd0, exp_rd.pop_front()});
                    stream_left = 3;
                end else if (stream_left > 0) begin
                    chk("stream_data_expected", {31'd0, exp_rd.size() > 0}, 32'd1);
                    if (exp_rd.size() > 0) chk("stream_rdata", {16'd0, o_rdata}, {16'd0, exp_rd.pop_front()});
                    stream_left--;
                end
                if (o_wr_ack) begin
                    chk("wr_ack_expected", {31'd0, exp_wack > 0}, 32'd1);
                    chk("wr_ack_after_mem_ack", {31'd0, prev_ack}, 32'd1);
                    if (exp_wack > 0) exp_wack--;
                end
                prev_ack = i_mem_ack;
            end
        end
    end

    task automatic chk_reset_vals(input string p);
        chk({p, "_fill"},      {31'd0, o_fill}, 32'd0);
        chk({p, "_rdata"},     {16'd0, o_rdata}, 32'd0);
        chk({p, "_wr_ack"},    {31'd0, o_wr_ack}, 32'd0);
        chk({p, "_busy"},      {31'd0, o_busy}, 32'd0);
        chk({p, "_mem_req"},   {31'd0, o_mem_req}, 32'd0);
        chk({p, "_mem_addr"},  o_mem_addr, 32'd0);
        chk({p, "_mem_we"},    {31'd0, o_mem_we}, 32'd0);
        chk({p, "_mem_wdata"}, {16'd0, o_mem_wdata}, 32'd0);
        chk({p, "_mem_bsel"},  {30'd0, o_mem_bsel}, 32'd3);
    endtask

    task automatic wait_fill(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = o_fill;
        end
        chk(name, {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 60 && o_busy; i++) @(negedge clk);
        chk(name, {31'd0, o_busy}, 32'd0);
    endtask

    task automatic wait_wr_ack(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            seen = o_wr_ack;
        end
        chk(name, {31'd0, seen}, 32'd1);
    endtask

    task automatic start_req(input logic [31:0] a, input logic rw, input logic [15:0] wd,
                             input logic wru, input logic wrl);
        @(negedge clk);
        i_req_addr = a; i_req_rw = rw; i_req_wdata = wd;
        i_req_wru = wru; i_req_wrl = wrl; i_req = 1'b1;
    endtask

    task automatic push_line(input logic [31:0] base, input logic [1:0] idx);
        logic [1:0] k;
        for (int j = 0; j < 4; j++) begin
            k = idx + 2'(j);
            push_mem({base[31:3], k, 1'b0}, 1'b0, 2'b11, 16'd0);
            exp_rd.push_back(16'h1111 * {14'd0, k});
        end
    endtask

    initial begin
        int base;
        reset = 1'b0; i_req = 1'b0; i_req_addr = 32'd0; i_req_rw = 1'b0;
        i_req_wdata = 16'd0; i_req_wrl = 1'b0; i_req_wru = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b1;

        // Read of an aligned line: critical word is word 0.
        push_line(32'h0000_0100, 2'd0);
        start_req(32'h0000_0100, 1'b1, 16'd0, 1'b0, 1'b0);
        wait_fill("rd100_fill");
        repeat (4) @(negedge clk);
        chk("rd100_busy_release", {31'd0, o_busy}, 32'd1);
        i_req = 1'b0;
        wait_idle("rd100_idle");

        // Critical word 3: wrap-around order.
        push_line(32'h0000_0106, 2'd3);
        start_req(32'h0000_0106, 1'b1, 16'd0, 1'b0, 1'b0);
        wait_fill("rd106_fill");
        repeat (4) @(negedge clk);
        i_req = 1'b0;
        wait_idle("rd106_idle");

        // Upper-byte write.
        push_mem(32'h0000_0200, 1'b1, 2'b10, 16'hBEEF);
        exp_wack++;
        start_req(32'h0000_0200, 1'b0, 16'hBEEF, 1'b1, 1'b0);
        wait_wr_ack("wr200_ack");
        i_req = 1'b0;
        wait_idle("wr200_idle");

        // Lower-byte write to an odd byte address.
        push_mem(32'h1234_5678, 1'b1, 2'b01, 16'h1234);
        exp_wack++;
        start_req(32'h1234_5679, 1'b0, 16'h1234, 1'b0, 1'b1);
        wait_wr_ack("wr_odd_ack");
        i_req = 1'b0;
        wait_idle("wr_odd_idle");

        // Request withdrawn during the third access: burst completes, no fill.
        base = n_acc;
        for (int j = 0; j < 4; j++) push_mem(32'h0000_0300 + 32'(2 * j), 1'b0, 2'b11, 16'd0);
        start_req(32'h0000_0300, 1'b1, 16'd0, 1'b0, 1'b0);
        for (int i = 0; i < 100 && n_acc < base + 3; i++) @(negedge clk);
        chk("abandon_third_access", n_acc - base, 32'd3);
        i_req = 1'b0;
        wait_idle("abandon_idle");
        chk("abandon_access_count", n_acc - base, 32'd4);
        chk("abandon_mem_req", {31'd0, o_mem_req}, 32'd0);

        // Request held long after fill: only one burst.
        base = n_acc;
        push_line(32'h0000_0108, 2'd0);
        start_req(32'h0000_0108, 1'b1, 16'd0, 1'b0, 1'b0);
        wait_fill("held_fill");
        repeat (10) @(negedge clk);
        chk("held_access_count", n_acc - base, 32'd4);
        chk("held_busy", {31'd0, o_busy}, 32'd1);
        chk("held_mem_req", {31'd0, o_mem_req}, 32'd0);
        i_req = 1'b0;
        wait_idle("held_idle");

        // Reset during STREAM, then a stray ack while idle.
        base = n_acc;
        for (int j = 0; j < 4; j++) push_mem(32'h0000_0100 + 32'(2 * j), 1'b0, 2'b11, 16'd0);
        exp_rd.push_back(16'h0000);
        exp_rd.push_back(16'h1111);
        start_req(32'h0000_0100, 1'b1, 16'd0, 1'b0, 1'b0);
        wait_fill("rst_fill");
        @(negedge clk);
        #1;
        reset = 1'b0;
        i_req = 1'b0;
        @(negedge clk);
        chk_reset_vals("stream_reset");
        reset = 1'b1;
        @(negedge clk);
        stray_req++;
        repeat (4) @(negedge clk);
        chk("stray_busy", {31'd0, o_busy}, 32'd0);
        chk("stray_mem_req", {31'd0, o_mem_req}, 32'd0);
        chk("stray_access_count", n_acc - base, 32'd4);

        chk("exp_mem_drained", exp_mem.size(), 32'd0);
        chk("exp_rd_drained", exp_rd.size(), 32'd0);
        chk("exp_wack_drained", exp_wack, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cache_fill_responder.md
CACHE_FILL_RESPONDER -- requirements
Module: cache_fill_responder

Interface
REQ-001 clk  in  1  system clock, all logic rising-edge.
REQ-002 reset  in  1  synchronous, active-low; clock clk.
REQ-003 req  in  1  cache request, level, held until serviced.
REQ-004 req_addr  in  32  byte address; [2:1] = critical word index.
REQ-005 req_rw  in  1  1=read burst, 0=single-word write.
REQ-006 req_wdata  in  16  write data.
REQ-007 req_wrl, req_wru  in  1 each  lower/upper byte write enables.
REQ-008 fill  out  1  one-cycle pulse: first burst word valid on rdata.
REQ-009 rdata  out  16  burst data to cache.
REQ-010 wr_ack  out  1  one-cycle pulse: write complete.
REQ-011 busy  out  1  high in any state except IDLE.
REQ-012 mem_req  out  1  memory access request.
REQ-013 mem_addr  out  32  memory word address.
REQ-014 mem_we  out  1  1=write access.
REQ-015 mem_wdata  out  16  memory write data.
REQ-016 mem_bsel  out  2  {upper,lower} byte selects.
REQ-017 mem_rdata  in  16  memory read data, valid when mem_ack=1.
REQ-018 mem_ack  in  1  single-cycle pulse per completed access.

Function
REQ-019 States SHALL be IDLE, FETCH, FILL, STREAM, WRITE, RELEASE.
REQ-020 IDLE: req=1 samples req_addr/req_rw/req_wdata/enables; next state FETCH if req_rw=1, else WRITE.
REQ-021 FETCH SHALL do four accesses in order idx, idx+1, idx+2, idx+3 (mod 4), idx=req_addr[2:1], mem_addr={req_addr[31:3],k,1'b0}.
REQ-022 mem_req SHALL be registered, asserted from the first FETCH/WRITE cycle, held continuously through the burst; mem_addr advances the cycle after each mem_ack; mem_req drops the cycle after the fourth ack.
REQ-023 Each mem_ack SHALL store mem_rdata into 4x16 buffer slot n (n = ack count 0..3).
REQ-024 After fourth ack: req=1 -> FILL; req=0 -> IDLE with no fill (abandoned burst).
REQ-025 FILL: fill=1, rdata=slot0, one cycle; STREAM SHALL drive rdata=slot1,2,3 on the next three consecutive cycles with fill=0, then RELEASE.
REQ-026 WRITE: mem_we=1, mem_addr={req_addr[31:1],1'b0}, mem_wdata=req_wdata, mem_bsel={req_wru,req_wrl}; on mem_ack drop mem_req and pulse wr_ack next cycle, then RELEASE.
REQ-027 RELEASE SHALL wait for req=0, then IDLE; a held req SHALL NOT start a second access.
REQ-028 mem_ack outside FETCH/WRITE SHALL be ignored.
REQ-029 mem_we=0, mem_bsel=2'b11 for reads.
REQ-030 Minimum read latency, req rise to fill: 2 + 4·(mem latency) cycles; no idle cycle between consecutive word accesses.

Reset
REQ-031 reset=0 at any edge SHALL force IDLE, clear buffer count; fill, wr_ack, busy, mem_req, mem_we = 0; rdata, mem_addr, mem_wdata = 0; mem_bsel = 2'b11.
REQ-032 Reset mid-burst SHALL abandon the burst; no fill or wr_ack follows.

Verification
REQ-033 Memory ack 2 cycles after each address; read 0x00000100 with mem[w]=w*0x1111 -> mem_addr 0x100,0x102,0x104,0x106; fill once; rdata 0x0000(idx0 word),0x1111·1..3 on consecutive cycles.
REQ-034 Read 0x00000106 -> mem_addr 0x106,0x100,0x102,0x104; rdata order same as fetch order.
REQ-035 Write 0x00000200, wdata=0xBEEF, wru=1, wrl=0 -> mem_we=1, mem_bsel=2'b10, mem_wdata=0xBEEF; wr_ack one cycle after mem_ack.
REQ-036 req dropped during third fetch -> fourth access completes, no fill, busy=0 after.
REQ-037 reset=0 during STREAM -> next cycle all outputs at reset values; stray mem_ack ignored.
REQ-038 req held high 10 cycles after fill -> exactly one burst of four mem accesses.
